// File: rtl/packet_sender_pkg.sv
// Shared NoC definitions for packet sender and receiver: default flit geometry,
// sender FSM encoding and a counter-width helper.
package packet_sender_pkg;

  localparam int unsigned NOC_DATA_W = 32;
  localparam int unsigned NOC_FLITS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_SEND     = 2'd2,
    ST_CHECK    = 2'd3
  } noc_state_e;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/packet_sender_if.sv
// Core-request and receiver-link signals of the packet sender.
// master = sender side, slave = core/receiver side.
interface packet_sender_if
  import packet_sender_pkg::*;
#(
  parameter int unsigned DATA_W = NOC_DATA_W,
  parameter int unsigned FLITS  = NOC_FLITS
);

  logic                    enable;
  logic                    req_valid;
  logic [FLITS*DATA_W-1:0] req_data;
  logic                    req_ready;
  logic                    ready;
  logic                    accept;
  logic                    start;
  logic                    finish;
  logic [DATA_W-1:0]       flit_data;
  logic                    done;
  logic                    fail;

  modport master (
    input  enable, req_valid, req_data, ready, accept,
    output req_ready, start, finish, flit_data, done, fail
  );

  modport slave (
    output enable, req_valid, req_data, ready, accept,
    input  req_ready, start, finish, flit_data, done, fail
  );

endinterface

// File: rtl/packet_sender.sv
// Packet sender: latches a FLITS-flit request, waits for the receiver, streams the
// flits one per cycle and resends on reject up to MAX_RETRY times.
module packet_sender
  import packet_sender_pkg::*;
#(
  parameter int unsigned DATA_W    = NOC_DATA_W,
  parameter int unsigned FLITS     = NOC_FLITS,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 16
) (
  input logic             clk,
  input logic             rst,
  packet_sender_if.master bus
);

  localparam int unsigned IW = cnt_w(FLITS);
  localparam int unsigned RW = cnt_w(MAX_RETRY + 1);
  localparam int unsigned TW = cnt_w(TIMEOUT);

  localparam logic [IW-1:0] LAST_IDX  = IW'(FLITS - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  noc_state_e              r_state;
  logic [FLITS*DATA_W-1:0] r_payload;
  logic [IW-1:0]           r_idx;
  logic [RW-1:0]           r_retry_cnt;
  logic [TW-1:0]           r_tmo_cnt;
  logic                    r_req_ready;
  logic                    r_start;
  logic                    r_finish;
  logic [DATA_W-1:0]       r_flit_data;
  logic                    r_done;
  logic                    r_fail;

  logic [IW-1:0]           w_next_idx;
  logic [DATA_W-1:0]       w_next_flit;

  assign w_next_idx = r_idx + 1'b1;

  always_comb begin
    w_next_flit = '0;
    for (int unsigned i = 0; i < FLITS; i++) begin
      if (w_next_idx == IW'(i)) w_next_flit = r_payload[i*DATA_W +: DATA_W];
    end
  end

  // Outputs are loaded on the edge that enters each state, so start/flit_data/finish
  // line up with the SEND cycles and done/fail appear the cycle after the decision.
  always_ff @(posedge clk) begin
    r_done <= 1'b0;
    r_fail <= 1'b0;
    if (rst) begin
      r_state     <= ST_IDLE;
      r_payload   <= '0;
      r_idx       <= '0;
      r_retry_cnt <= '0;
      r_tmo_cnt   <= '0;
      r_req_ready <= 1'b0;
      r_start     <= 1'b0;
      r_finish    <= 1'b0;
      r_flit_data <= '0;
    end else if (!bus.enable) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_retry_cnt <= '0;
      r_tmo_cnt   <= '0;
      r_req_ready <= 1'b0;
      r_start     <= 1'b0;
      r_finish    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_payload   <= bus.req_data;
            r_retry_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_req_ready <= 1'b0;
            r_state     <= ST_WAIT_RDY;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_WAIT_RDY: begin
          if (bus.ready) begin
            r_state     <= ST_SEND;
            r_idx       <= '0;
            r_tmo_cnt   <= '0;
            r_start     <= 1'b1;
            r_finish    <= (FLITS == 1);
            r_flit_data <= r_payload[DATA_W-1:0];
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_fail      <= 1'b1;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (r_idx == LAST_IDX) begin
            r_start  <= 1'b0;
            r_finish <= 1'b0;
            r_state  <= ST_CHECK;
          end else begin
            r_idx       <= w_next_idx;
            r_flit_data <= w_next_flit;
            r_finish    <= (w_next_idx == LAST_IDX);
          end
        end
        ST_CHECK: begin
          if (bus.accept) begin
            r_done      <= 1'b1;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (r_retry_cnt != RETRY_MAX) begin
            r_retry_cnt <= r_retry_cnt + 1'b1;
            r_state     <= ST_WAIT_RDY;
          end else begin
            r_fail      <= 1'b1;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.start     = r_start;
  assign bus.finish    = r_finish;
  assign bus.flit_data = r_flit_data;
  assign bus.done      = r_done;
  assign bus.fail      = r_fail;

endmodule
